// File: rtl/pe_lut_job_sequencer.sv
// Job sequencer for the PE-LUT wrapper: streams buffered CSR descriptors, writes the control
// register, polls ready bits until they match the enable mask or the poll budget runs out.
module pe_lut_job_sequencer #(
  parameter int unsigned RD_LATENCY = 2,    // must be >= 1
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned MAX_POLLS  = 1024  // must be >= 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_idx_i,
  input  logic [34:0] cfg_data_i,
  input  logic        go_i,
  input  logic [15:0] en_mask_i,
  input  logic [1:0]  result_cfg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_be_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i
);

  localparam int unsigned PollW = $clog2(MAX_POLLS + 1);
  localparam int unsigned WaitW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [PollW-1:0] PollMax  = PollW'(MAX_POLLS);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LATENCY - 1);
  localparam logic [GapW-1:0]  GapLast  = (POLL_GAP == 0) ? '0 : GapW'(POLL_GAP - 1);

  localparam logic [63:0] CsrBase    = 64'h0000_0000_6000_0000;
  localparam logic [63:0] CtrlAddr   = 64'h0000_0000_600f_0000;
  localparam logic [63:0] DecodeMiss = 64'hCA11_AB1E_BADC_AB1E;

  typedef enum logic [2:0] {
    StIdle,
    StWrCsr,
    StWrCtrl,
    StPollReq,
    StPollWait,
    StPollGap,
    StClr,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic [15:0]       mask_q, mask_d;
  logic [1:0]        rcfg_q, rcfg_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       ready_q, ready_d;
  logic [34:0]       buf_q [16];

  logic              busy;
  logic              rd_miss;
  logic              rd_match;

  assign rd_miss  = (mem_rdata_i == DecodeMiss);
  assign rd_match = !rd_miss && ((mem_rdata_i[63:48] & mask_q) == mask_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    gap_d       = gap_q;
    poll_d      = poll_q;
    mask_d      = mask_q;
    rcfg_d      = rcfg_q;
    timeout_d   = timeout_q;
    ready_d     = ready_q;
    busy        = 1'b1;
    done_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (go_i) begin
          mask_d    = en_mask_i;
          rcfg_d    = result_cfg_i;
          timeout_d = 1'b0;
          ready_d   = '0;
          poll_d    = '0;
          idx_d     = '0;
          // An empty mask skips all traffic and reports completion immediately.
          state_d   = (en_mask_i == '0) ? StDone : StWrCsr;
        end
      end

      StWrCsr: begin
        if (mask_q[idx_q]) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {CsrBase[63:7], idx_q, 3'b000};
          mem_wdata_o = {29'b0, buf_q[idx_q]};
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = StWrCtrl;
        end
      end

      StWrCtrl: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = CtrlAddr;
        mem_wdata_o = {46'b0, rcfg_q, mask_q};
        state_d     = StPollReq;
      end

      StPollReq: begin
        mem_req_o  = 1'b1;
        mem_addr_o = CtrlAddr;
        if (poll_q != PollMax) begin
          poll_d = poll_q + PollW'(1);
        end
        wait_d  = '0;
        state_d = StPollWait;
      end

      StPollWait: begin
        if (wait_q == WaitLast) begin
          // A decode-miss word carries no status, so it leaves ready_o clear.
          ready_d = rd_miss ? 16'h0000 : mem_rdata_i[63:48];
          if (rd_match) begin
            state_d = StClr;
          end else if (poll_q == PollMax) begin
            timeout_d = 1'b1;
            state_d   = StClr;
          end else if (POLL_GAP == 0) begin
            state_d = StPollReq;
          end else begin
            gap_d   = '0;
            state_d = StPollGap;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StPollGap: begin
        if (gap_q == GapLast) begin
          state_d = StPollReq;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      StClr: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = CtrlAddr;
        state_d    = StDone;
      end

      StDone: begin
        busy    = 1'b0;
        done_o  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      wait_q    <= '0;
      gap_q     <= '0;
      poll_q    <= '0;
      mask_q    <= '0;
      rcfg_q    <= '0;
      timeout_q <= 1'b0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
      mask_q    <= mask_d;
      rcfg_q    <= rcfg_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else if (cfg_we_i && !busy) begin
      buf_q[cfg_idx_i] <= cfg_data_i;
    end
  end

  assign busy_o    = busy;
  assign timeout_o = timeout_q;
  assign ready_o   = ready_q;
  assign mem_be_o  = mem_req_o ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_pe_lut_job_sequencer.sv
// Bench for pe_lut_job_sequencer: a job-level timeline model predicts every output cycle by cycle,
// plus literal checks for the directed job scenarios.
module tb_pe_lut_job_sequencer;

  localparam int RdLat  = 2;
  localparam int Gap    = 4;
  localparam int MaxP   = 4;
  localparam logic [63:0] Ctrl = 64'h0000_0000_600f_0000;
  localparam logic [63:0] Miss = 64'hCA11_AB1E_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [34:0] cfg_data;
  logic        go;
  logic [15:0] en_mask;
  logic [1:0]  result_cfg;
  logic        busy_o, done_o, timeout_o;
  logic [15:0] ready_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata;

  pe_lut_job_sequencer #(
    .RD_LATENCY (RdLat),
    .POLL_GAP   (Gap),
    .MAX_POLLS  (MaxP)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_data_i   (cfg_data),
    .go_i         (go),
    .en_mask_i    (en_mask),
    .result_cfg_i (result_cfg),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .ready_o      (ready_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [15:0] ready;
    logic        chk_ready;
  } exp_t;

  exp_t        exp_q[$];
  logic [34:0] bm [16];
  logic        m_tmo;
  logic [15:0] m_ready;
  logic [63:0] resp [16];
  int          nresp;

  int errors = 0;
  int checks = 0;

  // Job statistics gathered by the compare process.
  int          cyc, job_cyc, n_reqs, n_csr, done_at;
  int          rd_cyc[$];
  logic [63:0] first_csr_addr, last_csr_addr, first_csr_wdata, ctrl_wd;
  logic [15:0] done_ready;
  logic        done_tmo;

  // Wrapper read path: two register stages; idle stages hold a never-ready word.
  logic [63:0] s1;
  int          rd_idx;
  always @(posedge clk) begin
    if (go && !busy_o && !done_o) begin
      rd_idx <= 0;
    end else if (mem_req_o && !mem_we_o) begin
      s1     <= (rd_idx < nresp) ? resp[rd_idx] : 64'h0;
      rd_idx <= rd_idx + 1;
    end else begin
      s1 <= 64'h0000_5555_AAAA_5555;
    end
    mem_rdata <= s1;
  end

  function automatic void push(input logic req, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic busy, input logic done,
                               input logic tmo, input logic [15:0] ready, input logic chk);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.wdata = wdata; e.busy = busy;
    e.done = done; e.tmo = tmo; e.ready = ready; e.chk_ready = chk;
    exp_q.push_back(e);
  endfunction

  // Cycle-by-cycle prediction of one job, starting the cycle after go is accepted.
  function automatic void build_job(input logic [15:0] mask, input logic [1:0] cfg);
    logic        tmo;
    logic [15:0] rdy;
    logic [63:0] r;
    if (mask == 16'h0) begin
      push(0, 0, 0, 0, 0, 1, 0, 16'h0, 1);
      m_tmo = 0; m_ready = 0;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) push(1, 1, 64'h6000_0000 + 64'(8 * i), {29'b0, bm[i]}, 1, 0, 0, 0, 0);
      else         push(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    push(1, 1, Ctrl, {46'b0, cfg, mask}, 1, 0, 0, 0, 0);
    tmo = 0;
    rdy = 0;
    for (int p = 1; p <= MaxP; p++) begin
      push(1, 0, Ctrl, 0, 1, 0, 0, 0, 0);
      for (int w = 0; w < RdLat; w++) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
      r   = (p - 1 < nresp) ? resp[p-1] : 64'h0;
      rdy = (r == Miss) ? 16'h0 : r[63:48];
      if (r != Miss && (r[63:48] & mask) == mask) break;
      if (p == MaxP) begin
        tmo = 1;
        break;
      end
      for (int g = 0; g < Gap; g++) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    push(1, 1, Ctrl, 0, 1, 0, tmo, 0, 0);
    push(0, 0, 0, 0, 0, 1, tmo, rdy, 1);
    m_tmo = tmo;
    m_ready = rdy;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_buf(input logic [3:0] idx, input logic [34:0] data);
    @(posedge clk); #1;
    cfg_we = 1; cfg_idx = idx; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 0;
    bm[idx] = data;
  endtask

  task automatic run_job(input logic [15:0] mask, input logic [1:0] cfg, input int inject,
                         input int abort_at);
    @(posedge clk); #1;
    en_mask = mask; result_cfg = cfg; go = 1;
    @(posedge clk); #1;
    go = 0; en_mask = 16'($urandom); result_cfg = 2'($urandom);
    job_cyc = -1; n_reqs = 0; n_csr = 0; done_at = -1; rd_cyc.delete();
    ctrl_wd = 0; done_ready = 16'hDEAD; done_tmo = 0;
    build_job(mask, cfg);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      if (i == abort_at) begin
        rstn = 0;
        #1;
        check("reset_async_outputs",
              {busy_o, done_o, timeout_o, ready_o, mem_req_o, mem_we_o, mem_be_o, 28'h0},
              64'h0);
        check("reset_async_addr_wdata", mem_addr_o | mem_wdata_o, 64'h0);
        exp_q.delete();
        for (int k = 0; k < 16; k++) bm[k] = 0;
        m_tmo = 0; m_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1;
        return;
      end
      if (i == inject) begin
        go = 1; en_mask = 16'h5A5A; cfg_we = 1; cfg_idx = 0; cfg_data = 35'h1;
      end
      @(posedge clk); #1;
      go = 0; cfg_we = 0;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL job_drain: got %0d pending cycles expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic rand_job();
    logic [15:0] mask;
    logic [15:0] r16;
    repeat ($urandom_range(0, 3)) load_buf(4'($urandom), 35'({$urandom, $urandom}));
    mask  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
    nresp = MaxP;
    for (int p = 0; p < MaxP; p++) begin
      r16 = 16'($urandom);
      case ($urandom_range(0, 3))
        0: resp[p] = {mask | r16, 16'($urandom), 32'($urandom)};
        1: resp[p] = {r16, 16'($urandom), 32'($urandom)};
        2: resp[p] = (p < MaxP - 1) ? Miss : {r16, 48'h0};
        default: resp[p] = 64'h0;
      endcase
    end
    run_job(mask, 2'($urandom), -1, -1);
  endtask

  initial begin
    exp_t e;
    logic bad;
    rstn = 0; cfg_we = 0; cfg_idx = 0; cfg_data = 0; go = 0; en_mask = 0; result_cfg = 0;
    for (int k = 0; k < 16; k++) bm[k] = 0;
    m_tmo = 0; m_ready = 0; nresp = 0; cyc = 0; job_cyc = 0;
    s1 = 0; rd_idx = 0;

    fork
      forever begin
        @(negedge clk);
        if (rstn) begin
          cyc++; job_cyc++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
          end else begin
            e = '0; e.tmo = m_tmo; e.ready = m_ready; e.chk_ready = 1;
          end
          if (mem_req_o) begin
            n_reqs++;
            if (mem_we_o && mem_addr_o < Ctrl) begin
              if (n_csr == 0) begin
                first_csr_addr = mem_addr_o;
                first_csr_wdata = mem_wdata_o;
              end
              last_csr_addr = mem_addr_o;
              n_csr++;
            end
            if (mem_we_o && mem_addr_o == Ctrl && mem_wdata_o != 0) ctrl_wd = mem_wdata_o;
            if (!mem_we_o) rd_cyc.push_back(cyc);
          end
          if (done_o) begin
            done_ready = ready_o; done_tmo = timeout_o; done_at = job_cyc;
          end
          bad = (mem_req_o !== e.req) || (mem_we_o !== e.we) || (mem_addr_o !== e.addr) ||
                (mem_wdata_o !== e.wdata) || (busy_o !== e.busy) || (done_o !== e.done) ||
                (timeout_o !== e.tmo) || (e.chk_ready && ready_o !== e.ready) ||
                (e.req && mem_be_o !== 8'hFF);
          checks++;
          if (bad) begin
            errors++;
            $display({"FAIL cycle_cmp cyc=%0d got req=%b we=%b addr=%h wdata=%h busy=%b done=%b",
                      " tmo=%b rdy=%h expected req=%b we=%b addr=%h wdata=%h busy=%b done=%b",
                      " tmo=%b rdy=%h"},
                     cyc, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o,
                     timeout_o, ready_o, e.req, e.we, e.addr, e.wdata, e.busy, e.done, e.tmo,
                     e.ready);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {busy_o, done_o, timeout_o, ready_o, mem_req_o, mem_we_o, mem_be_o, 28'h0}, 64'h0);
    check("reset_addr_wdata", mem_addr_o | mem_wdata_o, 64'h0);
    rstn = 1;

    // T1 full job, ready after poll 3
    for (int i = 0; i < 16; i++) load_buf(4'(i), 35'h4_0000_0000 | 35'(i));
    nresp = 3;
    resp[0] = 64'h0; resp[1] = 64'h00FF_1234_0000_0000; resp[2] = 64'hFFFF_0000_0000_0000;
    run_job(16'hFFFF, 2'b10, -1, -1);
    check("t1_csr_writes", 64'(n_csr), 64'd16);
    check("t1_first_addr", first_csr_addr, 64'h6000_0000);
    check("t1_last_addr", last_csr_addr, 64'h6000_0078);
    check("t1_ctrl_wdata", ctrl_wd, 64'h0000_0000_0002_FFFF);
    check("t1_reads", 64'(rd_cyc.size()), 64'd3);
    check("t1_ready", {48'h0, done_ready}, 64'hFFFF);
    check("t1_timeout", {63'h0, done_tmo}, 64'h0);

    // T2 sparse mask
    nresp = 1; resp[0] = 64'hFFFF_0000_0000_0000;
    run_job(16'h8001, 2'b01, -1, -1);
    check("t2_csr_writes", 64'(n_csr), 64'd2);
    check("t2_first_addr", first_csr_addr, 64'h6000_0000);
    check("t2_last_addr", last_csr_addr, 64'h6000_0078);
    check("t2_ctrl_mask", {48'h0, ctrl_wd[15:0]}, 64'h8001);

    // T3 timeout
    nresp = 0;
    run_job(16'h00F0, 2'b00, -1, -1);
    check("t3_reads", 64'(rd_cyc.size()), 64'd4);
    for (int i = 1; i < rd_cyc.size(); i++)
      check("t3_read_spacing", 64'(rd_cyc[i] - rd_cyc[i-1]), 64'd7);
    check("t3_timeout", {63'h0, done_tmo}, 64'h1);

    // T4 partial then decode-miss then ready
    nresp = 3;
    resp[0] = 64'h0001_0000_0000_0000; resp[1] = Miss; resp[2] = 64'h0003_0000_0000_0000;
    run_job(16'h0003, 2'b11, -1, -1);
    check("t4_reads", 64'(rd_cyc.size()), 64'd3);
    check("t4_ready", {48'h0, done_ready}, 64'h0003);

    // T5 go and cfg_we while busy are dropped
    nresp = 1; resp[0] = 64'hFFFF_0000_0000_0000;
    run_job(16'h0001, 2'b01, 5, -1);
    run_job(16'h0001, 2'b01, -1, -1);
    check("t5_buf0_kept", first_csr_wdata, 64'h0000_0004_0000_0000);
    run_job(16'h0000, 2'b10, -1, -1);
    check("t5_mask0_reqs", 64'(n_reqs), 64'd0);
    check("t5_mask0_done_at", 64'(done_at), 64'd0);
    check("t5_mask0_ready", {48'h0, done_ready}, 64'h0);

    // T6 reset during first POLL_WAIT cycle, then a clean job
    nresp = 1; resp[0] = 64'hFFFF_0000_0000_0000;
    run_job(16'hFFFF, 2'b01, -1, 18);
    repeat (3) @(posedge clk);
    #1;
    run_job(16'h0F0F, 2'b11, -1, -1);
    check("t6_after_reset_csr", 64'(n_csr), 64'd8);
    check("t6_after_reset_ready", {48'h0, done_ready}, 64'hFFFF);

    repeat (40) rand_job();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
